avalon_reg_bank: RTL and testbench
==================================

// Module: avalon_reg_bank
// PURPOSE
//  Avalon-MM slave register bank that sits upstream of the 4:1 read-select stage.
//  Holds four WIDTH-bit registers: CTRL, DATA, STATUS and IRQ_MASK.
//  Captures hardware event pulses into sticky STATUS bits and raises a registered interrupt.
//  Returns read data with a fixed one-cycle latency to the QSYS fabric.
// PARAMETERS
//  WIDTH       32         register / bus data width (multiple of 8)
//  CTRL_RESET  32'h0      reset value of CTRL
// PORTS
//  clk            in   1          system clock, all logic rising-edge
//  reset_n        in   1          asynchronous active-low reset
//  address        in   3          word address from QSYS
//  read           in   1          read strobe, one cycle per access
//  write          in   1          write strobe, one cycle per access
//  writedata      in   WIDTH      write data
//  byteenable     in   WIDTH/8    per-byte write enable
//  readdata       out  WIDTH      read data, valid when readdatavalid=1
//  readdatavalid  out  1          one-cycle pulse, one cycle after read
//  event_in       in   WIDTH      hardware event pulses, one bit per STATUS bit
//  ctrl_out       out  WIDTH      current CTRL contents
//  data_out       out  WIDTH      current DATA contents
//  irq            out  1          registered interrupt, level
// BEHAVIOUR
//  Reset (reset_n=0, async):
//   - CTRL=CTRL_RESET; DATA, STATUS, IRQ_MASK = 0.
//   - readdata=0, readdatavalid=0, irq=0.
//   - An access in flight when reset asserts is dropped; no readdatavalid is issued.
//  Address map:
//   - 0 CTRL RW; 1 DATA RW; 2 STATUS W1C; 3 IRQ_MASK RW.
//   - 4..7 reserved: reads return 0 with a normal valid pulse; writes are ignored.
//  Write, on the edge where write=1:
//   - RW registers update only the bytes with byteenable[i]=1; other bytes hold.
//   - STATUS: each writedata bit =1 in an enabled byte clears that bit; 0 bits are unaffected.
//   - byteenable=0 means no effect.
//  STATUS set: every cycle, STATUS |= event_in.
//   - Simultaneous set and W1C clear of the same bit: set wins, and the bit ends at 1.
//  Read:
//   - read=1 in cycle N gives readdatavalid=1 in cycle N+1, with readdata = register value sampled at edge N.
//   - The sample is taken before any same-cycle write or event update.
//   - When readdatavalid=0, readdata holds its last value (no tri-state; the downstream stage owns bus drive).
//   - Back-to-back reads every cycle are supported, giving continuous valid pulses.
//  Read and write in the same cycle: both are performed; the read returns the pre-write value.
//  ctrl_out and data_out follow their registers with zero extra latency (direct register outputs).
//  irq:
//   - irq <= |(STATUS_next & IRQ_MASK_next).
//   - Asserts the cycle after an enabled event lands.
//   - Deasserts the cycle after the last enabled bit is cleared or masked.
//  No waitrequest: every access completes; no wait states.
// STRUCTURE
//  Shared package:
//   - Address constants ADDR_CTRL=3'd0, ADDR_DATA=3'd1, ADDR_STATUS=3'd2, ADDR_IRQ_MASK=3'd3.
//   - Register reset constants.
//  Sub-module byte_mask_write (WIDTH):
//   - new = (old & ~mask) | (wdata & mask).
//   - mask is expanded from byteenable.
//   - Used for the RW registers and, with an inverted form, for the W1C path.
//  All remaining logic stays in one always block per register plus a read-pipeline stage.
// TESTING
//  1. Release reset, then read addr 0..3 -> readdata = CTRL_RESET, 0, 0, 0; each valid exactly 1 cycle after read.
//  2. Write DATA=32'hDEADBEEF with be=4'b0101 onto 0 -> DATA=32'h00AD00EF; data_out matches the next cycle.
//  3. Pulse event_in=32'h11, write IRQ_MASK=32'h1 -> irq=1.
//     Then W1C STATUS with 32'h1 -> irq=0 one cycle later; STATUS reads 32'h10.
//  4. Same cycle: event_in bit 4 pulse and W1C 32'h10 -> STATUS bit 4 remains 1.
//  5. Same cycle read+write CTRL (old 32'h5, new 32'hA) -> readdata=32'h5, then a later read returns 32'hA.
//  6. Read addr 6, then write addr 6 -> readdata=0; all registers unchanged.
//     Assert reset_n mid-read -> no readdatavalid, all outputs at reset values.

Source files
------------

// File: rtl/avalon_reg_bank_pkg.sv
// Shared constants for the Avalon-MM register bank: word addresses and register reset values.
package avalon_reg_bank_pkg;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_DATA     = 3'd1;
  localparam logic [2:0] ADDR_STATUS   = 3'd2;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd3;

  localparam logic [31:0] CTRL_RESET_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] DATA_RESET         = 32'h0000_0000;
  localparam logic [31:0] STATUS_RESET       = 32'h0000_0000;
  localparam logic [31:0] IRQ_MASK_RESET     = 32'h0000_0000;

endpackage

// File: rtl/avalon_reg_bank_byte_mask_write.sv
// Byte-lane merge: lanes with byteenable set take wdata, the remaining lanes keep old_val.
module byte_mask_write
  import avalon_reg_bank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   old_val,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] byteenable,
  output logic [WIDTH-1:0]   new_val
);

  logic [WIDTH-1:0] mask;

  // Expand each byte enable into eight mask bits
  always_comb begin
    mask = '0;
    for (int i = 0; i < WIDTH/8; i++) begin
      mask[i*8 +: 8] = {8{byteenable[i]}};
    end
  end

  assign new_val = (old_val & ~mask) | (wdata & mask);

endmodule

// File: rtl/avalon_reg_bank.sv
// Avalon-MM slave with CTRL/DATA/STATUS(W1C, sticky events)/IRQ_MASK registers,
// one-cycle read latency and a registered level interrupt.
module avalon_reg_bank
  import avalon_reg_bank_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] CTRL_RESET = WIDTH'(CTRL_RESET_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               read,
  input  logic               write,
  input  logic [WIDTH-1:0]   writedata,
  input  logic [WIDTH/8-1:0] byteenable,
  output logic [WIDTH-1:0]   readdata,
  output logic               readdatavalid,
  input  logic [WIDTH-1:0]   event_in,
  output logic [WIDTH-1:0]   ctrl_out,
  output logic [WIDTH-1:0]   data_out,
  output logic               irq
);

  logic [WIDTH-1:0] ctrl_q, ctrl_d, data_q, data_d;
  logic [WIDTH-1:0] status_q, status_d, irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] readdata_q, readdata_d;
  logic             readdatavalid_q, readdatavalid_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] ctrl_wr, data_wr, irq_mask_wr, status_clr, read_mux;

  byte_mask_write #(.WIDTH(WIDTH)) u_ctrl_bmw (
    .old_val(ctrl_q), .wdata(writedata), .byteenable(byteenable), .new_val(ctrl_wr));
  byte_mask_write #(.WIDTH(WIDTH)) u_data_bmw (
    .old_val(data_q), .wdata(writedata), .byteenable(byteenable), .new_val(data_wr));
  byte_mask_write #(.WIDTH(WIDTH)) u_mask_bmw (
    .old_val(irq_mask_q), .wdata(writedata), .byteenable(byteenable), .new_val(irq_mask_wr));
  // W1C: enabled lanes load old & ~writedata, so written ones clear and zeros hold
  byte_mask_write #(.WIDTH(WIDTH)) u_status_bmw (
    .old_val(status_q), .wdata(status_q & ~writedata), .byteenable(byteenable),
    .new_val(status_clr));

  // CTRL next state
  always_comb begin
    if (write && (address == ADDR_CTRL)) ctrl_d = ctrl_wr;
    else                                 ctrl_d = ctrl_q;
  end

  // DATA next state
  always_comb begin
    if (write && (address == ADDR_DATA)) data_d = data_wr;
    else                                 data_d = data_q;
  end

  // IRQ_MASK next state
  always_comb begin
    if (write && (address == ADDR_IRQ_MASK)) irq_mask_d = irq_mask_wr;
    else                                     irq_mask_d = irq_mask_q;
  end

  // STATUS next state; events are OR-ed after the clear so a same-cycle set wins
  always_comb begin
    if (write && (address == ADDR_STATUS)) status_d = status_clr | event_in;
    else                                   status_d = status_q | event_in;
  end

  // Read pipeline samples pre-update register values; readdata holds when idle
  always_comb begin
    case (address)
      ADDR_CTRL:     read_mux = ctrl_q;
      ADDR_DATA:     read_mux = data_q;
      ADDR_STATUS:   read_mux = status_q;
      ADDR_IRQ_MASK: read_mux = irq_mask_q;
      default:       read_mux = '0;
    endcase
    if (read) readdata_d = read_mux;
    else      readdata_d = readdata_q;
    readdatavalid_d = read;
    irq_d           = |(status_d & irq_mask_d);
  end

  // All state flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q          <= CTRL_RESET;
      data_q          <= WIDTH'(DATA_RESET);
      status_q        <= WIDTH'(STATUS_RESET);
      irq_mask_q      <= WIDTH'(IRQ_MASK_RESET);
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      irq_q           <= 1'b0;
    end else begin
      ctrl_q          <= ctrl_d;
      data_q          <= data_d;
      status_q        <= status_d;
      irq_mask_q      <= irq_mask_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
      irq_q           <= irq_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = readdatavalid_q;
  assign ctrl_out      = ctrl_q;
  assign data_out      = data_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_avalon_reg_bank.sv
// Directed bench for avalon_reg_bank: read results are queued when a read is issued
// and popped when readdatavalid appears.
module tb_avalon_reg_bank;

  localparam int          W        = 32;
  localparam logic [31:0] CTRL_RST = 32'hC0DE_0001;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [2:0]   address;
  logic         read, write;
  logic [31:0]  writedata;
  logic [3:0]   byteenable;
  logic [31:0]  readdata;
  logic         readdatavalid;
  logic [31:0]  event_in;
  logic [31:0]  ctrl_out, data_out;
  logic         irq;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] sb[$];

  avalon_reg_bank #(.WIDTH(W), .CTRL_RESET(CTRL_RST)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
    .readdatavalid(readdatavalid), .event_in(event_in), .ctrl_out(ctrl_out),
    .data_out(data_out), .irq(irq));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock with the currently driven inputs, then check the read channel.
  task automatic cycle();
    logic rd_issued;
    logic [31:0] exp;
    rd_issued = read;
    @(negedge clk);
    check("rvalid", {31'd0, readdatavalid}, {31'd0, rd_issued});
    if (readdatavalid === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp = sb.pop_front();
        check("rdata", readdata, exp);
      end
    end
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp);
    address = a; read = 1'b1; sb.push_back(exp);
    cycle();
    read = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a; write = 1'b1; writedata = d; byteenable = be;
    cycle();
    write = 1'b0; byteenable = 4'h0;
  endtask

  initial begin
    reset_n = 1'b0; address = 3'd0; read = 1'b0; write = 1'b0;
    writedata = 32'h0; byteenable = 4'h0; event_in = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_rvalid", {31'd0, readdatavalid}, 32'd0);
    check("rst_rdata", readdata, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_ctrl", ctrl_out, CTRL_RST);
    check("rst_data", data_out, 32'h0);
    reset_n = 1'b1;

    // Back-to-back reads of the four registers
    rd(3'd0, CTRL_RST); rd(3'd1, 32'h0); rd(3'd2, 32'h0); rd(3'd3, 32'h0);
    cycle();

    // Byte-masked DATA write and no-op write with byteenable=0
    wr(3'd1, 32'hDEADBEEF, 4'b0101);
    check("data_out_be", data_out, 32'h00AD00EF);
    wr(3'd1, 32'hFFFFFFFF, 4'b0000);
    check("data_out_be0", data_out, 32'h00AD00EF);
    rd(3'd1, 32'h00AD00EF);

    // Sticky events, interrupt mask and W1C
    event_in = 32'h11; cycle(); event_in = 32'h0;
    check("irq_unmasked", {31'd0, irq}, 32'd0);
    wr(3'd3, 32'h1, 4'hF);
    check("irq_set", {31'd0, irq}, 32'd1);
    rd(3'd2, 32'h11);
    wr(3'd2, 32'h1, 4'hF);
    check("irq_clr", {31'd0, irq}, 32'd0);
    rd(3'd2, 32'h10);

    // Same-cycle event set and W1C of bit 4: set wins
    event_in = 32'h10; address = 3'd2; write = 1'b1; writedata = 32'h10; byteenable = 4'hF;
    cycle();
    event_in = 32'h0; write = 1'b0; byteenable = 4'h0;
    rd(3'd2, 32'h10);
    wr(3'd3, 32'h10, 4'hF);
    check("irq_bit4", {31'd0, irq}, 32'd1);
    wr(3'd3, 32'h0, 4'hF);
    check("irq_masked", {31'd0, irq}, 32'd0);
    wr(3'd2, 32'h10, 4'b0001);
    rd(3'd2, 32'h0);

    // Same-cycle read and write of CTRL returns the old value
    wr(3'd0, 32'h5, 4'hF);
    address = 3'd0; read = 1'b1; write = 1'b1; writedata = 32'hA; byteenable = 4'hF;
    sb.push_back(32'h5);
    cycle();
    read = 1'b0; write = 1'b0; byteenable = 4'h0;
    check("ctrl_out_a", ctrl_out, 32'hA);
    rd(3'd0, 32'hA);
    cycle();
    check("rdata_hold", readdata, 32'hA);
    wr(3'd0, 32'h11223344, 4'b1000);
    check("ctrl_out_b3", ctrl_out, 32'h1100000A);

    // Reserved address: read zero, write ignored
    rd(3'd6, 32'h0);
    wr(3'd6, 32'hFFFFFFFF, 4'hF);
    rd(3'd0, 32'h1100000A); rd(3'd1, 32'h00AD00EF); rd(3'd2, 32'h0); rd(3'd3, 32'h0);

    // Raise irq, then assert reset mid-read
    wr(3'd3, 32'h1, 4'hF);
    event_in = 32'h1; cycle(); event_in = 32'h0;
    check("irq_pre_rst", {31'd0, irq}, 32'd1);
    address = 3'd0; read = 1'b1;
    #2 reset_n = 1'b0;
    @(negedge clk);
    read = 1'b0;
    check("midrst_rvalid", {31'd0, readdatavalid}, 32'd0);
    check("midrst_rdata", readdata, 32'h0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    check("midrst_ctrl", ctrl_out, CTRL_RST);
    check("midrst_data", data_out, 32'h0);
    reset_n = 1'b1;
    rd(3'd2, 32'h0); rd(3'd3, 32'h0);
    cycle();
    check("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
